// File: rtl/rf_alu_pkg.sv
// Shared types and constants for the RF/ALU sequencer: state encoding,
// ALUOp classes and R-type instruction field positions.
package rf_alu_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    EXEC = 3'd2,
    WB   = 3'd3,
    DONE = 3'd4
  } seq_state_t;

  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BEQ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [5:0] OP_RTYPE = 6'h00;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  // 5-bit instruction register fields address a 6-bit register space
  function automatic logic [5:0] zext_reg(input logic [4:0] field);
    return {1'b0, field};
  endfunction

endpackage

// File: rtl/rf_alu_seq_decode.sv
// Combinational R-type decoder: register addresses, funct, ALU class,
// illegal-opcode flag and write-back qualifier.
module rf_alu_seq_decode
  import rf_alu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [5:0]  read1,
  output logic [5:0]  read2,
  output logic [5:0]  write_reg,
  output logic [5:0]  func_code,
  output logic [1:0]  alu_op,
  output logic        illegal,
  output logic        write_en
);

  logic [5:0] op_s;
  logic [4:0] rs_s;
  logic [4:0] rt_s;
  logic [4:0] rd_s;
  logic       unused_shamt_s;

  assign op_s = instr[OP_MSB:OP_LSB];
  assign rs_s = instr[RS_MSB:RS_LSB];
  assign rt_s = instr[RT_MSB:RT_LSB];
  assign rd_s = instr[RD_MSB:RD_LSB];
  assign unused_shamt_s = ^instr[10:6];

  // Field extraction, ALU class selection and write-back qualification
  always_comb begin
    read1     = zext_reg(rs_s);
    read2     = zext_reg(rt_s);
    write_reg = zext_reg(rd_s);
    func_code = instr[FUNCT_MSB:FUNCT_LSB];
    alu_op    = ALUOP_MEM;
    illegal   = 1'b0;
    write_en  = 1'b0;
    if (op_s == OP_RTYPE) begin
      alu_op   = ALUOP_RTYPE;
      illegal  = 1'b0;
      // register 0 is read-only, so a write to it is dropped
      write_en = (rd_s != 5'd0);
    end else begin
      alu_op   = ALUOP_MEM;
      illegal  = 1'b1;
      write_en = 1'b0;
    end
  end

endmodule

// File: rtl/rf_alu_sequencer.sv
// Five-state initiator driving the RF/ALU datapath for one R-type instruction
// per handshake. Optional counters enabled by macro RF_ALU_SEQ_PERF_EN.
module rf_alu_sequencer
  import rf_alu_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [5:0]  Read1,
  output logic [5:0]  Read2,
  output logic [5:0]  FuncCode,
  output logic [1:0]  ALUOp,
  input  logic [31:0] ALUOut,
  input  logic        Zero,
  output logic [5:0]  WriteReg,
  output logic [31:0] WriteData,
  output logic        RegWrite,
  output logic        done,
  output logic [31:0] result,
  output logic        zero_flag,
  output logic        illegal
`ifdef RF_ALU_SEQ_PERF_EN
  ,
  output logic [15:0] retired,
  output logic [7:0]  illegal_cnt
`endif
);

  seq_state_t state_r;
  logic       handshake_s;
  logic [5:0] dec_read1_s;
  logic [5:0] dec_read2_s;
  logic [5:0] dec_write_reg_s;
  logic [5:0] dec_func_code_s;
  logic [1:0] dec_alu_op_s;
  logic       dec_illegal_s;
  logic       dec_write_en_s;
  logic       write_en_r;
  logic       illegal_op_r;
  logic       regwrite_r;

  assign handshake_s = instr_valid && instr_ready;

  rf_alu_seq_decode u_decode (
    .instr     (instr),
    .read1     (dec_read1_s),
    .read2     (dec_read2_s),
    .write_reg (dec_write_reg_s),
    .func_code (dec_func_code_s),
    .alu_op    (dec_alu_op_s),
    .illegal   (dec_illegal_s),
    .write_en  (dec_write_en_s)
  );

  // Reset must also kill a strobe already in flight during WB
  assign RegWrite = regwrite_r & reset_n;

  // Sequencer FSM; the decoded fields registered at the handshake form the instruction latch
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      instr_ready  <= 1'b1;
      Read1        <= 6'd0;
      Read2        <= 6'd0;
      FuncCode     <= 6'd0;
      ALUOp        <= 2'b00;
      WriteReg     <= 6'd0;
      WriteData    <= 32'd0;
      regwrite_r   <= 1'b0;
      done         <= 1'b0;
      result       <= 32'd0;
      zero_flag    <= 1'b0;
      illegal      <= 1'b0;
      write_en_r   <= 1'b0;
      illegal_op_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (handshake_s) begin
            Read1        <= dec_read1_s;
            Read2        <= dec_read2_s;
            FuncCode     <= dec_func_code_s;
            ALUOp        <= dec_alu_op_s;
            WriteReg     <= dec_write_reg_s;
            write_en_r   <= dec_write_en_s;
            illegal_op_r <= dec_illegal_s;
            instr_ready  <= 1'b0;
            state_r      <= READ;
          end
        end
        READ: begin
          state_r <= EXEC;
        end
        EXEC: begin
          result     <= ALUOut;
          zero_flag  <= Zero;
          WriteData  <= ALUOut;
          regwrite_r <= write_en_r;
          state_r    <= WB;
        end
        WB: begin
          regwrite_r <= 1'b0;
          done       <= 1'b1;
          illegal    <= illegal_op_r;
          state_r    <= DONE;
        end
        DONE: begin
          done        <= 1'b0;
          illegal     <= 1'b0;
          instr_ready <= 1'b1;
          state_r     <= IDLE;
        end
        default: begin
          regwrite_r  <= 1'b0;
          done        <= 1'b0;
          illegal     <= 1'b0;
          instr_ready <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

`ifdef RF_ALU_SEQ_PERF_EN
  // Retirement and illegal-opcode counters, both advanced while in DONE
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      retired     <= 16'd0;
      illegal_cnt <= 8'd0;
    end else if (state_r == DONE) begin
      retired <= retired + 16'd1;
      if (illegal && (illegal_cnt != 8'hFF)) begin
        illegal_cnt <= illegal_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rf_alu_sequencer.sv
// Directed self-checking bench for rf_alu_sequencer with a small RF/ALU model.
module tb_rf_alu_sequencer;

  logic        clock;
  logic        reset_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [5:0]  Read1;
  logic [5:0]  Read2;
  logic [5:0]  FuncCode;
  logic [1:0]  ALUOp;
  logic [31:0] ALUOut;
  logic        Zero;
  logic [5:0]  WriteReg;
  logic [31:0] WriteData;
  logic        RegWrite;
  logic        done;
  logic [31:0] result;
  logic        zero_flag;
  logic        illegal;
`ifdef RF_ALU_SEQ_PERF_EN
  logic [15:0] retired;
  logic [7:0]  illegal_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int done_cnt = 0;

  logic [31:0] rf [0:63];

  rf_alu_sequencer dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .Read1       (Read1),
    .Read2       (Read2),
    .FuncCode    (FuncCode),
    .ALUOp       (ALUOp),
    .ALUOut      (ALUOut),
    .Zero        (Zero),
    .WriteReg    (WriteReg),
    .WriteData   (WriteData),
    .RegWrite    (RegWrite),
    .done        (done),
    .result      (result),
    .zero_flag   (zero_flag),
    .illegal     (illegal)
`ifdef RF_ALU_SEQ_PERF_EN
    ,
    .retired     (retired),
    .illegal_cnt (illegal_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Datapath model: register file with reset preload, write port, strobe counters
  always @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 64; i++) begin
        rf[i] <= (i == 1) ? 32'd5 : (i == 2) ? 32'd7 : (i == 4) ? 32'hDEAD_BEEF : 32'd0;
      end
    end else if (RegWrite) begin
      rf[WriteReg] <= WriteData;
    end
    if (RegWrite) wr_cnt <= wr_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  // Asynchronous-read ALU model
  always_comb begin
    ALUOut = 32'd0;
    case (ALUOp)
      2'b00: ALUOut = rf[Read1] + rf[Read2];
      2'b01: ALUOut = rf[Read1] - rf[Read2];
      2'b10: begin
        case (FuncCode)
          6'h20: ALUOut = rf[Read1] + rf[Read2];
          6'h22: ALUOut = rf[Read1] - rf[Read2];
          6'h24: ALUOut = rf[Read1] & rf[Read2];
          6'h25: ALUOut = rf[Read1] | rf[Read2];
          default: ALUOut = 32'd0;
        endcase
      end
      default: ALUOut = 32'd0;
    endcase
  end
  assign Zero = (ALUOut == 32'd0);

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [4:0] rd,
                                      input logic [5:0] funct);
    return {op, rs, rt, rd, 5'd0, funct};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // per-instruction observations
  logic        c1_ready;
  logic [5:0]  c1_r1, c1_r2, c1_fc, c2_r1, c2_r2;
  logic [1:0]  c1_op;
  logic        c3_rw;
  logic [5:0]  c3_wr;
  logic [31:0] c3_wd;
  logic        c4_done, c4_ill, c4_zero, c4_rw;
  logic [31:0] c4_res;
  int          rw_other;
  int          done_early;

  task automatic run(input logic [31:0] ins);
    @(negedge clock);
    instr = ins;
    instr_valid = 1'b1;
    @(negedge clock);
    instr_valid = 1'b0;
    c1_ready = instr_ready; c1_r1 = Read1; c1_r2 = Read2; c1_fc = FuncCode; c1_op = ALUOp;
    rw_other = int'(RegWrite); done_early = int'(done);
    @(negedge clock);
    c2_r1 = Read1; c2_r2 = Read2;
    rw_other += int'(RegWrite); done_early += int'(done);
    @(negedge clock);
    c3_rw = RegWrite; c3_wr = WriteReg; c3_wd = WriteData; done_early += int'(done);
    @(negedge clock);
    c4_done = done; c4_ill = illegal; c4_res = result; c4_zero = zero_flag; c4_rw = RegWrite;
  endtask

  int          w0, d0, ready_lo;
  logic        ready_c5, rw_pre;
  logic [5:0]  b_r1, b_r2, b_fc;
  logic [31:0] res_a, res_b;

  initial begin
    reset_n = 1'b0;
    instr_valid = 1'b0;
    instr = 32'd0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    chk("rst_ctrl", {27'd0, instr_ready, RegWrite, done, illegal, zero_flag}, 32'h10);
    chk("rst_addr", {Read1, Read2, WriteReg, FuncCode}, 32'd0);
    chk("rst_aluop", {30'd0, ALUOp}, 32'd0);
    chk("rst_wdata", WriteData, 32'd0);
    chk("rst_result", result, 32'd0);
`ifdef RF_ALU_SEQ_PERF_EN
    chk("rst_perf", {8'd0, retired, illegal_cnt}, 32'd0);
`endif

    // add r3,r1,r2 -> 12
    run(enc(6'h00, 5'd1, 5'd2, 5'd3, 6'h20));
    chk("add_ready_c1", {31'd0, c1_ready}, 32'd0);
    chk("add_reads_c1", {c1_r1, c1_r2}, {20'd0, 6'd1, 6'd2});
    chk("add_ctrl_c1", {c1_fc, c1_op}, {24'd0, 6'h20, 2'b10});
    chk("add_reads_c2", {c2_r1, c2_r2}, {20'd0, 6'd1, 6'd2});
    chk("add_wb_c3", {c3_rw, c3_wr}, {25'd0, 1'b1, 6'd3});
    chk("add_wdata_c3", c3_wd, 32'd12);
    chk("add_flags_c4", {c4_done, c4_ill, c4_zero, c4_rw}, 32'b1000);
    chk("add_result", c4_res, 32'd12);
    chk("add_timing", rw_other * 16 + done_early, 32'd0);
    chk("add_rf3", rf[3], 32'd12);

    // add r2,r1,r0 -> r2=5
    run(enc(6'h00, 5'd1, 5'd0, 5'd2, 6'h20));
    chk("mov_result", c4_res, 32'd5);
    chk("mov_rf2", rf[2], 32'd5);

    // sub r4,r1,r2 -> 0, overwrites preloaded r4
    run(enc(6'h00, 5'd1, 5'd2, 5'd4, 6'h22));
    chk("sub_wb_c3", {c3_rw, c3_wr}, {25'd0, 1'b1, 6'd4});
    chk("sub_wdata_c3", c3_wd, 32'd0);
    chk("sub_res_zero", {c4_res[30:0], c4_zero}, 32'd1);
    chk("sub_rf4", rf[4], 32'd0);

    // add r5,r4,r1 sees r4=0
    run(enc(6'h00, 5'd4, 5'd1, 5'd5, 6'h20));
    chk("raw_read1", {26'd0, c1_r1}, 32'd4);
    chk("raw_result", {c4_res[30:0], c4_zero}, {31'd5, 1'b0});

    // or r0,r1,r3 -> 13, no write
    w0 = wr_cnt;
    run(enc(6'h00, 5'd1, 5'd3, 5'd0, 6'h25));
    chk("rd0_rw_c3", {31'd0, c3_rw}, 32'd0);
    chk("rd0_done", {31'd0, c4_done}, 32'd1);
    chk("rd0_result", c4_res, 32'd13);
    chk("rd0_nowrite", wr_cnt - w0, 32'd0);
    chk("rd0_rf0", rf[0], 32'd0);

    // op 6'h23 -> illegal, ALUOp MEM, no write
    w0 = wr_cnt;
    run(enc(6'h23, 5'd1, 5'd2, 5'd6, 6'h20));
    chk("ill_aluop", {30'd0, c1_op}, 32'd0);
    chk("ill_done_ill", {30'd0, c4_done, c4_ill}, 32'b11);
    chk("ill_result", c4_res, 32'd10);
    chk("ill_nowrite", {31'd0, c3_rw} + (wr_cnt - w0), 32'd0);
    @(negedge clock);
    chk("ill_cleared", {30'd0, done, illegal}, 32'd0);
`ifdef RF_ALU_SEQ_PERF_EN
    chk("perf_illegal_cnt", {24'd0, illegal_cnt}, 32'd1);
    chk("perf_retired", {16'd0, retired}, 32'd6);
`endif

    // back-to-back: A=add r7,r1,r3 (17), B=sub r8,r3,r1 (7), valid held high
    d0 = done_cnt; w0 = wr_cnt; ready_lo = 0;
    @(negedge clock);
    instr = enc(6'h00, 5'd1, 5'd3, 5'd7, 6'h20);
    instr_valid = 1'b1;
    @(negedge clock);
    instr = enc(6'h00, 5'd3, 5'd1, 5'd8, 6'h22);
    ready_lo += int'(!instr_ready);
    for (int k = 2; k <= 4; k++) begin
      @(negedge clock);
      ready_lo += int'(!instr_ready);
    end
    res_a = result;
    @(negedge clock);
    ready_c5 = instr_ready;
    @(negedge clock);
    instr_valid = 1'b0;
    b_r1 = Read1; b_r2 = Read2; b_fc = FuncCode;
    repeat (3) @(negedge clock);
    res_b = result;
    repeat (3) @(negedge clock);
    chk("b2b_ready_low", ready_lo, 32'd4);
    chk("b2b_ready_c5", {31'd0, ready_c5}, 32'd1);
    chk("b2b_a_result", res_a, 32'd17);
    chk("b2b_b_read", {b_r1, b_r2, b_fc}, {14'd0, 6'd3, 6'd1, 6'h22});
    chk("b2b_b_result", res_b, 32'd7);
    chk("b2b_done_cnt", done_cnt - d0, 32'd2);
    chk("b2b_wr_cnt", wr_cnt - w0, 32'd2);
    chk("b2b_rf78", {rf[7][15:0], rf[8][15:0]}, {16'd17, 16'd7});
    chk("b2b_idle", {31'd0, instr_ready}, 32'd1);

    // reset asserted during WB of add r9,r1,r1
    @(negedge clock);
    instr = enc(6'h00, 5'd1, 5'd1, 5'd9, 6'h20);
    instr_valid = 1'b1;
    @(negedge clock);
    instr_valid = 1'b0;
    repeat (2) @(negedge clock);
    rw_pre = RegWrite;
    d0 = done_cnt; w0 = wr_cnt;
    reset_n = 1'b0;
    #1;
    chk("wbrst_rw_pre", {31'd0, rw_pre}, 32'd1);
    chk("wbrst_rw_gated", {31'd0, RegWrite}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    chk("wbrst_ctrl", {27'd0, instr_ready, RegWrite, done, illegal, zero_flag}, 32'h10);
    chk("wbrst_addr", {Read1, Read2, WriteReg, FuncCode}, 32'd0);
    chk("wbrst_data", WriteData | result | {30'd0, ALUOp}, 32'd0);
`ifdef RF_ALU_SEQ_PERF_EN
    chk("wbrst_perf", {8'd0, retired, illegal_cnt}, 32'd0);
`endif
    repeat (4) @(negedge clock);
    chk("wbrst_no_done", done_cnt - d0, 32'd0);
    chk("wbrst_no_write", wr_cnt - w0, 32'd0);
    chk("wbrst_rf9", rf[9], 32'd0);

    // recovery after reset
    run(enc(6'h00, 5'd1, 5'd2, 5'd3, 6'h20));
    chk("recover_result", {c4_res[30:0], c4_done}, {31'd12, 1'b1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_alu_sequencer.md
# rf_alu_sequencer

Multi-cycle initiator that drives the register-file/ALU datapath from the control side. It accepts one 32-bit R-type instruction per valid/ready handshake and decodes the rs/rt/rd/funct fields. It sequences the datapath's read ports, ALU controls and write-back port, captures the ALU result and Zero flag, and reports completion. It sits between an instruction source (bench or future fetch unit) and the RF_ALU datapath.

## Interface
Parameters:
- none; widths are fixed at 6-bit register index, 32-bit data, 6-bit funct and 2-bit ALUOp.

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- instr_valid  in  1  instruction source presents `instr`.
- instr  in  32  [31:26] op, [25:21] rs, [20:16] rt, [15:11] rd, [5:0] funct.
- instr_ready  out  1  sequencer can accept an instruction.
- Read1, Read2  out  6  datapath read addresses; rs and rt zero-extended to 6 bits.
- FuncCode  out  6  funct field to the ALU control.
- ALUOp  out  2  ALU control class.
- ALUOut  in  32  datapath ALU result.
- Zero  in  1  datapath zero flag.
- WriteReg  out  6  write-back address; rd zero-extended to 6 bits.
- WriteData  out  32  write-back data.
- RegWrite  out  1  one-cycle write strobe.
- done  out  1  one-cycle completion pulse.
- result  out  32  captured ALUOut; stable from `done` until the next capture.
- zero_flag  out  1  captured Zero.
- illegal  out  1  one-cycle pulse, coincident with `done`, when op ≠ 6'h00.

## Operation
- FSM states:
  - IDLE: instr_ready=1. A handshake latches instr → READ.
  - READ: Read1, Read2, FuncCode and ALUOp driven from the latch → EXEC.
  - EXEC: the same drives are held. ALUOut and Zero are captured into result and zero_flag at the end of the cycle → WB.
  - WB: RegWrite=1 with WriteReg=rd and WriteData=result → DONE.
  - DONE: done=1 → IDLE.
- Holding the read addresses for two cycles covers a datapath with either asynchronous or one-cycle-registered reads.
- Decode:
  - op=6'h00: ALUOp=2'b10 (R-type).
  - op≠6'h00: ALUOp=2'b00. The instruction still sequences, but RegWrite is suppressed and illegal pulses in DONE.
- rd=0: RegWrite suppressed because register 0 is read-only by convention. result is still captured and done still pulses.
- Outside READ/EXEC, Read1, Read2, FuncCode and ALUOp hold their last values. Outside WB, RegWrite=0.
- The instruction latch updates only on a handshake. instr_valid outside IDLE is ignored, not queued.

## Timing
- Handshake: an instruction transfers on the rising edge where instr_valid && instr_ready.
- Latency: handshake edge = cycle 0; READ = cycle 1; EXEC = cycle 2; WB = cycle 3; done = cycle 4. The next instruction is accepted no earlier than the cycle-5 edge.
- Throughput: one instruction per 5 cycles.
- Back-to-back instructions: WB writes at the cycle-3 edge, and the following instruction reads at ≥ cycle 6, so read-after-write dependencies need no forwarding.
- Reset:
  - Any clock edge with reset_n=0 forces IDLE and aborts any in-flight instruction; no RegWrite is issued for it.
  - Output values after reset: instr_ready=1; RegWrite=0, done=0, illegal=0, zero_flag=0.
  - Read1, Read2, WriteReg, FuncCode, ALUOp, WriteData and result are all 0.

## Configuration
- RF_ALU_SEQ_PERF_EN
  - Defined: adds output `retired` (16-bit) and output `illegal_cnt` (8-bit).
    - retired increments in every DONE state.
    - illegal_cnt increments on each illegal pulse and saturates at 8'hFF.
    - Both counters reset to 0; retired wraps at 16'hFFFF → 0.
  - Undefined: neither port nor any counter logic exists; all other behaviour is identical.

## Structure
- Package rf_alu_pkg holds:
  - the state encoding (IDLE, READ, EXEC, WB, DONE);
  - ALUOp constants: ALUOP_MEM=2'b00, ALUOP_BEQ=2'b01, ALUOP_RTYPE=2'b10;
  - OP_RTYPE=6'h00;
  - instruction field bit positions.
- One sub-module, rf_alu_seq_decode: a combinational decoder from the latched instr to Read1, Read2, WriteReg, FuncCode, ALUOp, an illegal flag and a write-enable qualifier.

## Test plan
- Preload r1=5, r2=7; issue add r3,r1,r2 (funct 6'h20) → Read1=1 and Read2=2 in READ/EXEC; RegWrite with WriteReg=3 and WriteData=12 in cycle 3; done in cycle 4 with result=12, zero_flag=0.
- With r1=5, r2=5, issue sub r4,r1,r2 (funct 6'h22) → result=0, zero_flag=1, write of 0 to r4; a following add reading r4 sees 0.
- Issue or r0,r1,r2 (rd=0) → result captured and done pulses, but RegWrite stays 0 in every cycle.
- Issue op=6'h23 → illegal and done pulse together in cycle 4, no RegWrite; with RF_ALU_SEQ_PERF_EN, illegal_cnt=1 and retired=1.
- Hold instr_valid high with two different instructions queued → instr_ready low in cycles 1–4, second instruction accepted at the cycle-5 edge, no instruction dropped or duplicated.
- Assert reset_n=0 during WB → RegWrite=0 on that edge, state returns to IDLE, done never pulses, every output at its reset value.
